kitchen_timer: RTL and testbench

Three-preset kitchen countdown timer (1, 2 or 3 minutes) with start, pause/clear and alarm.
- Time is shown as minutes (binary) and seconds (two BCD digits).
- A prescaler turns the system clock into a 1 Hz decrement tick.
- Top-level block; the push-button inputs are assumed to be already synchronised to clk.

---
 rtl/kitchen_timer_pkg.sv | 53 +++++
 rtl/kitchen_timer_prescaler.sv | 29 ++
 rtl/kitchen_timer.sv | 139 +++++++++++++
 tb/tb_kitchen_timer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen countdown timer.
// Holds the FSM state, button events, presets and the BCD decrement.
package kitchen_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    RUN,
    PAUSE,
    ALARM
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_STOP,
    EV_START,
    EV_MODE
  } event_t;

  localparam int DIGIT_W = 4;
  localparam int SEC_W   = 2 * DIGIT_W;

  localparam logic [1:0] PRESET_MIN_1 = 2'd1;
  localparam logic [1:0] PRESET_MIN_2 = 2'd2;
  localparam logic [1:0] PRESET_MIN_3 = 2'd3;
  localparam logic [SEC_W-1:0] PRESET_SEC = 8'h00;

  typedef struct packed {
    logic [1:0]       minute;
    logic [SEC_W-1:0] second;
  } clock_t;

  // One-second BCD down-count; 0:00 stays 0:00.
  function automatic clock_t clock_dec(input clock_t t);
    clock_t r;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
    r     = t;
    tens  = t.second[SEC_W-1:DIGIT_W];
    units = t.second[DIGIT_W-1:0];
    if (units != '0) begin
      r.second[DIGIT_W-1:0] = units - DIGIT_W'(1);
    end else if (tens != '0) begin
      r.second[SEC_W-1:DIGIT_W] = tens - DIGIT_W'(1);
      r.second[DIGIT_W-1:0]     = DIGIT_W'(9);
    end else if (t.minute != '0) begin
      r.minute = t.minute - 2'd1;
      r.second = 8'h59;
    end
    return r;
  endfunction

endpackage

// File: rtl/kitchen_timer_prescaler.sv
// Divides clk down to a one-cycle tick every TICKS_PER_SEC enabled cycles.
// clear restarts the count so the first tick is a full period away.
module kitchen_timer_prescaler #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/kitchen_timer.sv
// Three-preset countdown timer: button edges, control FSM
// and the minute/BCD-second down-counter.
module kitchen_timer
  import kitchen_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  input  logic             start,
  input  logic             mode_1min,
  input  logic             mode_2min,
  input  logic             mode_3min,
  output logic             alarm,
  output logic [1:0]       minute,
  output logic [SEC_W-1:0] second
);

  logic [4:0] btn;
  logic [4:0] prev;
  logic [4:0] press;
  event_t     ev;
  logic [1:0] preset;

  state_t state_q, state_d;
  clock_t cnt_q, cnt_d, dec;
  logic   alarm_q, alarm_d;
  logic   tick, pre_clear, pre_enable, dec_zero;

  assign btn   = {stop, start, mode_3min, mode_2min, mode_1min};
  assign press = btn & ~prev;

  // Only the highest-priority fresh press is acted on.
  always_comb begin
    ev     = EV_NONE;
    preset = PRESET_MIN_1;
    priority case (1'b1)
      press[4]: ev = EV_STOP;
      press[3]: ev = EV_START;
      press[2]: begin
        ev     = EV_MODE;
        preset = PRESET_MIN_3;
      end
      press[1]: begin
        ev     = EV_MODE;
        preset = PRESET_MIN_2;
      end
      press[0]: begin
        ev     = EV_MODE;
        preset = PRESET_MIN_1;
      end
      default: ;
    endcase
  end

  assign pre_clear  = (state_q == READY || state_q == PAUSE)
                   && (ev == EV_START);
  assign pre_enable = (state_q == RUN) && (ev != EV_STOP);

  kitchen_timer_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (pre_clear),
    .enable(pre_enable),
    .tick  (tick)
  );

  assign dec      = clock_dec(cnt_q);
  assign dec_zero = (dec == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      prev    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      prev    <= btn;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ev == EV_MODE) state_d = READY;
      end
      READY, PAUSE: begin
        unique case (ev)
          EV_MODE:  state_d = READY;
          EV_START: state_d = RUN;
          EV_STOP:  state_d = IDLE;
          default:  ;
        endcase
      end
      RUN: begin
        if (ev == EV_STOP)          state_d = PAUSE;
        else if (tick && dec_zero)  state_d = ALARM;
      end
      ALARM: begin
        unique case (ev)
          EV_MODE: state_d = READY;
          EV_STOP: state_d = IDLE;
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ev == EV_MODE) cnt_d = '{preset, PRESET_SEC};
      end
      READY, PAUSE, ALARM: begin
        if (ev == EV_MODE)      cnt_d = '{preset, PRESET_SEC};
        else if (ev == EV_STOP) cnt_d = '0;
      end
      RUN: begin
        if (ev != EV_STOP && tick) cnt_d = dec;
      end
      default: cnt_d = '0;
    endcase
    alarm_d = (state_d == ALARM);
  end

  assign alarm  = alarm_q;
  assign minute = cnt_q.minute;
  assign second = cnt_q.second;

endmodule

// File: tb/tb_kitchen_timer.sv
// Directed and random checks of kitchen_timer against a
// seconds-remaining reference model.
module tb_kitchen_timer;

  localparam int T = 1;
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] RST  = 6'b100000;
  localparam logic [5:0] STP  = 6'b010000;
  localparam logic [5:0] STA  = 6'b001000;
  localparam logic [5:0] M3   = 6'b000100;
  localparam logic [5:0] M2   = 6'b000010;
  localparam logic [5:0] M1   = 6'b000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stop = 1'b0;
  logic       start = 1'b0;
  logic       mode_1min = 1'b0;
  logic       mode_2min = 1'b0;
  logic       mode_3min = 1'b0;
  logic       alarm;
  logic [1:0] minute;
  logic [7:0] second;

  int total = 0;
  int bad = 0;

  // model: phase 0 idle,1 ready,2 run,3 pause,4 alarm
  int         m_ph = 0;
  int         m_rem = 0;
  int         m_pc = 0;
  logic [4:0] m_prev = '0;

  kitchen_timer #(.TICKS_PER_SEC(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .stop     (stop),
    .start    (start),
    .mode_1min(mode_1min),
    .mode_2min(mode_2min),
    .mode_3min(mode_3min),
    .alarm    (alarm),
    .minute   (minute),
    .second   (second)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    logic [4:0] in;
    logic [4:0] pr;
    int sel;
    int load;
    in = {stop, start, mode_3min, mode_2min, mode_1min};
    if (reset) begin
      m_ph = 0; m_rem = 0; m_pc = 0; m_prev = '0;
      return;
    end
    pr = in & ~m_prev;
    m_prev = in;
    sel = 0; load = 0;
    if (pr[4])      sel = 1;
    else if (pr[3]) sel = 2;
    else if (pr[2]) begin sel = 3; load = 180; end
    else if (pr[1]) begin sel = 3; load = 120; end
    else if (pr[0]) begin sel = 3; load = 60; end
    case (m_ph)
      0: if (sel == 3) begin m_rem = load; m_ph = 1; end
      1, 3: begin
        if (sel == 3) begin m_rem = load; m_ph = 1; end
        else if (sel == 2) begin m_ph = 2; m_pc = 0; end
        else if (sel == 1) begin m_rem = 0; m_ph = 0; end
      end
      2: begin
        if (sel == 1) m_ph = 3;
        else begin
          m_pc++;
          if (m_pc == T) begin
            m_pc = 0;
            m_rem--;
            if (m_rem == 0) m_ph = 4;
          end
        end
      end
      4: begin
        if (sel == 1) m_ph = 0;
        else if (sel == 3) begin m_rem = load; m_ph = 1; end
      end
      default: ;
    endcase
  endtask

  task automatic check_model();
    logic [1:0] em;
    logic [7:0] es;
    logic       ea;
    int s;
    em = 2'(m_rem / 60);
    s  = m_rem % 60;
    es = 8'((s / 10) * 16 + (s % 10));
    ea = (m_ph == 4);
    total++;
    assert (minute === em) else begin
      bad++;
      $error("FAIL minute got=%0d exp=%0d", minute, em);
    end
    total++;
    assert (second === es) else begin
      bad++;
      $error("FAIL second got=%h exp=%h", second, es);
    end
    total++;
    assert (alarm === ea) else begin
      bad++;
      $error("FAIL alarm got=%b exp=%b", alarm, ea);
    end
  endtask

  task automatic expect_const(input string tag, input logic [1:0] em,
                              input logic [7:0] es, input logic ea);
    total++;
    assert (minute === em && second === es && alarm === ea) else begin
      bad++;
      $error("FAIL %s got=%0d:%h al=%b exp=%0d:%h al=%b",
             tag, minute, second, alarm, em, es, ea);
    end
  endtask

  task automatic cyc(input logic [5:0] v);
    {reset, stop, start, mode_3min, mode_2min, mode_1min} = v;
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  initial begin
    logic [5:0] v;
    // reset and held-button single load
    cyc(RST);
    expect_const("reset", 2'd0, 8'h00, 1'b0);
    cyc(M2); cyc(M2); cyc(M2);
    expect_const("m2_held", 2'd2, 8'h00, 1'b0);
    cyc(M1);
    expect_const("m1_load", 2'd1, 8'h00, 1'b0);
    cyc(NONE);
    // full countdown to alarm
    cyc(STA);
    expect_const("run_start", 2'd1, 8'h00, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      cyc(NONE);
      if (i == 1)  expect_const("first_dec", 2'd0, 8'h59, 1'b0);
      if (i == 11) expect_const("tens_borrow", 2'd0, 8'h49, 1'b0);
    end
    expect_const("alarm_hit", 2'd0, 8'h00, 1'b1);
    cyc(STA);
    expect_const("alarm_start_ign", 2'd0, 8'h00, 1'b1);
    cyc(NONE);
    cyc(STP);
    expect_const("alarm_stop", 2'd0, 8'h00, 1'b0);
    cyc(NONE);
    cyc(M1); cyc(STA);
    for (int i = 0; i < 60; i++) cyc(NONE);
    expect_const("alarm_again", 2'd0, 8'h00, 1'b1);
    cyc(M2);
    expect_const("alarm_mode", 2'd2, 8'h00, 1'b0);
    cyc(NONE);
    // pause, resume, stop twice
    cyc(M1); cyc(STA);
    for (int i = 0; i < 8; i++) cyc(NONE);
    cyc(STP);
    for (int i = 0; i < 5; i++) cyc(NONE);
    expect_const("pause_hold", 2'd0, 8'h52, 1'b0);
    cyc(STA);
    cyc(NONE);
    expect_const("resume", 2'd0, 8'h51, 1'b0);
    cyc(STP); cyc(NONE); cyc(STP);
    expect_const("stop_twice", 2'd0, 8'h00, 1'b0);
    cyc(NONE);
    // preset from pause, minute borrow
    cyc(M1); cyc(STA);
    for (int i = 0; i < 8; i++) cyc(NONE);
    cyc(STP);
    cyc(M3);
    expect_const("pause_m3", 2'd3, 8'h00, 1'b0);
    cyc(STA);
    cyc(NONE);
    expect_const("min_borrow", 2'd2, 8'h59, 1'b0);
    cyc(STP); cyc(NONE); cyc(STP); cyc(NONE);
    // reset mid-run, simultaneous start+stop
    cyc(M1); cyc(STA); cyc(NONE); cyc(NONE); cyc(NONE);
    cyc(RST);
    expect_const("reset_run", 2'd0, 8'h00, 1'b0);
    cyc(NONE);
    cyc(M2); cyc(NONE);
    cyc(STA | STP);
    expect_const("start_stop", 2'd0, 8'h00, 1'b0);
    cyc(NONE);
    cyc(STA); cyc(NONE);
    expect_const("idle_start_ign", 2'd0, 8'h00, 1'b0);
    // random traffic
    v = NONE;
    for (int i = 0; i < 4000; i++) begin
      v[5] = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) v[4] = ~v[4];
      if ($urandom_range(0, 5) == 0)  v[3] = ~v[3];
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 19) == 0) v[b] = ~v[b];
      cyc(v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
